// File: rtl/ppc_muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM state codes and CR0 bit positions.
// Latency: n/a (declarations only).  Backpressure: n/a.
package ppc_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULLW  = 3'b000,
        OP_MULHW  = 3'b001,
        OP_MULHWU = 3'b010,
        OP_DIVW   = 3'b100,
        OP_DIVWU  = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CR0_LT = 2;
    localparam int CR0_GT = 1;
    localparam int CR0_EQ = 0;

    function automatic logic op_is_legal(input logic [2:0] code);
        logic ok;
        case (code)
            OP_MULLW, OP_MULHW, OP_MULHWU, OP_DIVW, OP_DIVWU: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ppc_muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring divide step.
// Latency: combinational; the caller registers hi/lo every CALC cycle.
// Backpressure: none, evaluated every cycle.
module ppc_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        shifted = {hi, lo[WIDTH-1]};
        fits    = shifted >= {1'b0, dvs};
        if (is_div) begin
            // Remainder always stays below the divisor, so the W-bit difference is exact when it fits.
            hi_nxt = fits ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], fits};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ppc_muldiv.sv
// Iterative PowerPC mullw/mulhw/mulhwu/divw/divwu unit; optional early-out via MULDIV_EARLY_OUT_EN.
// Latency: done WIDTH+1 cycles after start (1 cycle for div error / illegal op).
// Backpressure: start ignored while busy; flush aborts with no done and result unchanged.
module ppc_muldiv
    import ppc_muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                flush,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    C,
    output logic                OV,
    output logic [2:0]          CR0
);
    localparam int              CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    op_t              op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, dvs, hi_nxt, lo_nxt;
    logic             neg, special, spec_ov, is_div, calc_last;

    // Decode of the launch request
    logic [2:0]       op_code;
    logic             op_legal, op_div, op_signed, a_neg, b_neg, div_err;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_code   = op[2:0];
    assign op_legal  = ((op >> 3) == '0) && op_is_legal(op_code);
    assign op_div    = op_code[2];
    assign op_signed = (op_code == OP_MULLW) || (op_code == OP_MULHW) || (op_code == OP_DIVW);
    assign a_neg     = op_signed && A[WIDTH-1];
    assign b_neg     = op_signed && B[WIDTH-1];
    assign mag_a     = a_neg ? -A : A;
    assign mag_b     = b_neg ? -B : B;
    assign div_err   = op_div && ((B == '0) ||
                       ((op_code == OP_DIVW) && (A == MIN_NEG) && (B == '1)));
    assign is_div    = (op_q == OP_DIVW) || (op_q == OP_DIVWU);

`ifdef MULDIV_EARLY_OUT_EN
    logic early;
    assign calc_last = (cnt == LAST) || early;
`else
    assign calc_last = (cnt == LAST);
`endif

    ppc_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .hi     (hi),
        .lo     (lo),
        .dvs    (dvs),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Sign correction and result selection, applied on the DONE->IDLE edge
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH:0]     prod_top;
    logic [WIDTH-1:0]   quo_s, res_c;
    logic               res_ov;

    always_comb begin
        prod     = {hi, lo};
        prod_s   = neg ? -prod : prod;
        prod_top = prod_s[2*WIDTH-1:WIDTH-1];
        quo_s    = neg ? -lo : lo;
        res_c    = '0;
        res_ov   = 1'b0;
        if (special) begin
            res_c  = spec_ov ? '0 : '1;
            res_ov = spec_ov;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (early) begin
            res_c  = '0;
`endif
        end else begin
            case (op_q)
                OP_MULLW: begin
                    res_c  = prod_s[WIDTH-1:0];
                    res_ov = !((&prod_top) || (prod_top == '0));
                end
                OP_MULHW, OP_MULHWU: res_c = prod_s[2*WIDTH-1:WIDTH];
                default:             res_c = quo_s;
            endcase
        end
    end

    function automatic logic [2:0] cr0_of(input logic [WIDTH-1:0] c);
        logic [2:0] r;
        r         = '0;
        r[CR0_LT] = c[WIDTH-1];
        r[CR0_GT] = !c[WIDTH-1] && (c != '0);
        r[CR0_EQ] = (c == '0);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_MULLW;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            dvs     <= '0;
            neg     <= 1'b0;
            special <= 1'b0;
            spec_ov <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            C       <= '0;
            OV      <= 1'b0;
            CR0     <= cr0_of('0);
`ifdef MULDIV_EARLY_OUT_EN
            early   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q    <= op_t'(op_code);
                        cnt     <= '0;
                        hi      <= '0;
                        lo      <= mag_a;
                        dvs     <= mag_b;
                        neg     <= a_neg ^ b_neg;
                        special <= !op_legal || div_err;
                        spec_ov <= op_legal && div_err;
                        busy    <= 1'b1;
                        state   <= (!op_legal || div_err) ? ST_DONE : ST_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        early   <= op_div ? (mag_a < mag_b) : ((A == '0) || (B == '0));
`endif
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hi  <= hi_nxt;
                        lo  <= lo_nxt;
                        cnt <= cnt + CW'(1);
                        if (calc_last) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        C    <= res_c;
                        OV   <= res_ov;
                        CR0  <= cr0_of(res_c);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
